// File: rtl/neuron_step_seq.sv
// neuron_step_seq: sequencer for one fixed-point perceptron neuron.
// Loads a bias, multiply-accumulates N_INPUTS (x, w) pairs into a saturating signed accumulator,
// applies a step activation (y = 1 iff sum > 0) and holds the result on a valid/ready output.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      begin an evaluation (sampled only in IDLE)
//   i_bias       signed initial accumulator value, sampled with i_start
//   i_in_valid   x/w pair present
//   o_in_ready   pair accepted this cycle (high only in ACCUM)
//   i_in_x       signed input activation
//   i_in_w       signed weight
//   o_out_valid  result available (high only in OUT)
//   i_out_ready  consumer accepts the result
//   o_out_y      step activation result
//   o_out_sum    signed final accumulator value
//   o_busy       high in every state except IDLE
module neuron_step_seq #(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned DATA_W   = 5,
  parameter int unsigned ACC_W    = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic signed [ACC_W-1:0]  i_bias,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic signed [DATA_W-1:0] i_in_x,
  input  logic signed [DATA_W-1:0] i_in_w,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_out_y,
  output logic signed [ACC_W-1:0]  o_out_sum,
  output logic                     o_busy
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_ACT   = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]              r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_out_y;
  logic signed [ACC_W-1:0] r_out_sum;

  logic signed [ACC_W-1:0] w_x_ext;
  logic signed [ACC_W-1:0] w_w_ext;
  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W:0]   w_sum_wide;
  logic signed [ACC_W-1:0] w_sum_sat;
  logic                    w_beat;

  // Operands are sign-extended to ACC_W first; the full product always fits in 2*DATA_W bits.
  always_comb begin
    w_x_ext = ACC_W'(i_in_x);
    w_w_ext = ACC_W'(i_in_w);
    w_prod  = w_x_ext * w_w_ext;
    w_sum_wide = {r_acc[ACC_W-1], r_acc} + {w_prod[ACC_W-1], w_prod};
    // Overflow when the two top bits of the widened sum disagree; clamp toward the sign.
    if (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]) begin
      w_sum_sat = w_sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      w_sum_sat = w_sum_wide[ACC_W-1:0];
    end
  end

  assign w_beat = (r_state == ST_ACCUM) && i_in_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_out_y   <= 1'b0;
      r_out_sum <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_acc   <= i_bias;
            r_cnt   <= '0;
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_beat) begin
            r_acc <= w_sum_sat;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_BEAT) begin
              r_state <= ST_ACT;
            end
          end
        end
        ST_ACT: begin
          r_out_sum <= r_acc;
          r_out_y   <= (r_acc[ACC_W-1] == 1'b0) && (r_acc != '0);
          r_state   <= ST_OUT;
        end
        ST_OUT: begin
          if (i_out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs are decoded from state only, so no input reaches an output combinationally.
  assign o_in_ready  = (r_state == ST_ACCUM);
  assign o_out_valid = (r_state == ST_OUT);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_out_y     = r_out_y;
  assign o_out_sum   = r_out_sum;

endmodule

// File: tb/tb_neuron_step_seq.sv
module tb_neuron_step_seq;

  typedef int arr_t[4];

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic signed [9:0] i_bias = '0;
  logic              i_in_valid = 1'b0;
  logic              o_in_ready;
  logic signed [4:0] i_in_x = '0;
  logic signed [4:0] i_in_w = '0;
  logic              o_out_valid;
  logic              i_out_ready = 1'b0;
  logic              o_out_y;
  logic signed [9:0] o_out_sum;
  logic              o_busy;

  int n_checks = 0;
  int n_fail = 0;

  neuron_step_seq #(
    .N_INPUTS(4),
    .DATA_W  (5),
    .ACC_W   (10)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_bias     (i_bias),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_in_x     (i_in_x),
    .i_in_w     (i_in_w),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_out_y    (o_out_y),
    .o_out_sum  (o_out_sum),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Reference: plain integer MAC, clamped to the 10-bit signed range after every beat.
  function automatic int model_sum(input int bias, input arr_t xs, input arr_t ws);
    int a;
    a = bias;
    for (int i = 0; i < 4; i++) begin
      a = a + xs[i] * ws[i];
      if (a > 511) a = 511;
      if (a < -512) a = -512;
    end
    return a;
  endfunction

  function automatic int model_y(input int s);
    return (s > 0) ? 1 : 0;
  endfunction

  // Drives one evaluation up to the first cycle with out_valid high. Called 1 time unit after
  // a rising edge. lat = edges from the start edge until out_valid is seen.
  // stall_mode: 0 = in_valid always high, 1 = pattern 1,0,0,..., 2 = random.
  task automatic run_eval(input int bias, input arr_t xs, input arr_t ws, input int stall_mode,
                          output int sum, output int y, output int lat);
    int idx;
    int p;
    int guard;
    logic beat;
    i_start = 1'b1;
    i_bias  = 10'(bias);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    lat = 0;
    idx = 0;
    p = 0;
    guard = 0;
    while (idx < 4 && guard < 200) begin
      case (stall_mode)
        0:       i_in_valid = 1'b1;
        1:       i_in_valid = (p % 3 == 0);
        default: i_in_valid = 1'($urandom_range(0, 1));
      endcase
      i_in_x = 5'(xs[idx]);
      i_in_w = 5'(ws[idx]);
      beat = i_in_valid && o_in_ready;
      @(posedge i_clk);
      #1;
      lat++;
      p++;
      guard++;
      if (beat) idx++;
    end
    i_in_valid = 1'b0;
    while (!o_out_valid && guard < 200) begin
      @(posedge i_clk);
      #1;
      lat++;
      guard++;
    end
    if (guard >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_eval_timeout: out_valid=%0b after %0d cycles, required 1", o_out_valid,
               guard);
    end
    sum = int'(o_out_sum);
    y = int'(o_out_y);
  endtask

  task automatic handshake();
    i_out_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({o_busy, o_in_ready, o_out_valid, o_out_y} !== 4'b0000 || o_out_sum !== 10'sd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%0b in_ready=%0b out_valid=%0b y=%0b sum=%0d, required all 0",
               o_busy, o_in_ready, o_out_valid, o_out_y, o_out_sum);
    end
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    // in_valid in IDLE is ignored and does not start anything
    i_in_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_in_valid = 1'b0;
    n_checks++;
    if (o_busy !== 1'b0 || o_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_valid: busy=%0b in_ready=%0b, required 0 0", o_busy, o_in_ready);
    end
  endtask

  task automatic test_positive();
    arr_t xs = '{1, 2, 3, 4};
    arr_t ws = '{1, 1, 1, 1};
    int s, y, lat;
    run_eval(0, xs, ws, 0, s, y, lat);
    n_checks++;
    if (s !== 10 || y !== 1) begin
      n_fail++;
      $display("FAIL positive_sum: sum=%0d y=%0d, required 10 1", s, y);
    end
    n_checks++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL positive_latency: out_valid after %0d edges, required 5", lat);
    end
    handshake();
    n_checks++;
    if (o_busy !== 1'b0 || o_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL positive_release: busy=%0b out_valid=%0b, required 0 0", o_busy, o_out_valid);
    end
  endtask

  task automatic test_zero_neg();
    arr_t xs0 = '{2, -2, 0, 0};
    arr_t ws0 = '{3, 3, 5, 5};
    arr_t xs1 = '{1, 1, 1, 1};
    arr_t ws1 = '{-1, -1, -1, -1};
    int s, y, lat;
    run_eval(0, xs0, ws0, 0, s, y, lat);
    n_checks++;
    if (s !== 0 || y !== 0) begin
      n_fail++;
      $display("FAIL zero_sum: sum=%0d y=%0d, required 0 0", s, y);
    end
    handshake();
    run_eval(3, xs1, ws1, 0, s, y, lat);
    n_checks++;
    if (s !== -1 || y !== 0) begin
      n_fail++;
      $display("FAIL negative_sum: sum=%0d y=%0d, required -1 0", s, y);
    end
    handshake();
  endtask

  task automatic test_saturation();
    arr_t xa = '{15, 15, 15, 15};
    arr_t xb = '{-16, -16, -16, -16};
    arr_t wb = '{15, 15, 15, 15};
    arr_t xc = '{15, -16, 0, 0};
    arr_t wc = '{15, 15, 0, 0};
    int s, y, lat;
    run_eval(500, xa, xa, 0, s, y, lat);
    n_checks++;
    if (s !== 511 || y !== 1) begin
      n_fail++;
      $display("FAIL sat_positive: sum=%0d y=%0d, required 511 1", s, y);
    end
    handshake();
    run_eval(-500, xb, wb, 0, s, y, lat);
    n_checks++;
    if (s !== -512 || y !== 0) begin
      n_fail++;
      $display("FAIL sat_negative: sum=%0d y=%0d, required -512 0", s, y);
    end
    handshake();
    run_eval(511, xc, wc, 0, s, y, lat);
    n_checks++;
    if (s !== 271 || y !== 1) begin
      n_fail++;
      $display("FAIL sat_then_recover: sum=%0d y=%0d, required 271 1", s, y);
    end
    handshake();
  endtask

  task automatic test_stall();
    arr_t xs = '{1, 2, 3, 4};
    arr_t ws = '{1, 1, 1, 1};
    int s, y, lat;
    run_eval(0, xs, ws, 1, s, y, lat);
    n_checks++;
    if (s !== 10 || y !== 1) begin
      n_fail++;
      $display("FAIL stall_sum: sum=%0d y=%0d, required 10 1", s, y);
    end
    n_checks++;
    if (lat !== 11) begin
      n_fail++;
      $display("FAIL stall_latency: out_valid after %0d edges, required 11", lat);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    arr_t xs = '{3, -2, 7, 1};
    arr_t ws = '{5, 4, -3, 9};
    int s, y, lat, exp_s;
    exp_s = model_sum(-20, xs, ws);
    run_eval(-20, xs, ws, 0, s, y, lat);
    n_checks++;
    if (s !== exp_s || y !== model_y(exp_s)) begin
      n_fail++;
      $display("FAIL bp_result: sum=%0d y=%0d, required %0d %0d", s, y, exp_s, model_y(exp_s));
    end
    for (int c = 0; c < 5; c++) begin
      i_start = c[0];
      i_bias = 10'sd100;
      @(posedge i_clk);
      #1;
      n_checks++;
      if (o_out_valid !== 1'b1 || int'(o_out_sum) !== exp_s || int'(o_out_y) !== model_y(exp_s)
          || o_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: valid=%0b sum=%0d y=%0b in_ready=%0b, required 1 %0d %0d 0",
                 c, o_out_valid, o_out_sum, o_out_y, o_in_ready, exp_s, model_y(exp_s));
      end
    end
    i_start = 1'b0;
    handshake();
    n_checks++;
    if (o_out_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: valid=%0b busy=%0b, required 0 0", o_out_valid, o_busy);
    end
    @(posedge i_clk);
    #1;
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_queued_start: busy=%0b, required 0", o_busy);
    end
  endtask

  task automatic test_reset_mid();
    arr_t xs = '{1, 1, 1, 1};
    arr_t ws = '{2, 2, 2, 2};
    int s, y, lat;
    i_start = 1'b1;
    i_bias = 10'sd200;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1 || o_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_response: busy=%0b in_ready=%0b, required 1 1", o_busy, o_in_ready);
    end
    i_in_valid = 1'b1;
    i_in_x = 5'sd7;
    i_in_w = 5'sd7;
    repeat (2) begin
      @(posedge i_clk);
      #1;
    end
    i_in_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_busy, o_in_ready, o_out_valid, o_out_y} !== 4'b0000 || o_out_sum !== 10'sd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: busy=%0b in_ready=%0b valid=%0b y=%0b sum=%0d, required 0",
               o_busy, o_in_ready, o_out_valid, o_out_y, o_out_sum);
    end
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    run_eval(0, xs, ws, 0, s, y, lat);
    n_checks++;
    if (s !== 8 || y !== 1) begin
      n_fail++;
      $display("FAIL after_reset_eval: sum=%0d y=%0d, required 8 1", s, y);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    arr_t xa = '{10, 11, 12, 13};
    arr_t wa = '{9, 9, 9, 9};
    arr_t xb = '{-1, 2, -3, 4};
    arr_t wb = '{5, 5, 5, 5};
    int s, y, lat;
    run_eval(7, xa, wa, 0, s, y, lat);
    n_checks++;
    if (s !== model_sum(7, xa, wa) || y !== 1) begin
      n_fail++;
      $display("FAIL b2b_first: sum=%0d y=%0d, required %0d 1", s, y, model_sum(7, xa, wa));
    end
    handshake();
    run_eval(-11, xb, wb, 0, s, y, lat);
    n_checks++;
    if (s !== -1 || y !== 0 || lat !== 5) begin
      n_fail++;
      $display("FAIL b2b_second: sum=%0d y=%0d lat=%0d, required -1 0 5", s, y, lat);
    end
    handshake();
  endtask

  task automatic test_random();
    arr_t xs, ws;
    int bias, s, y, lat, exp_s;
    for (int t = 0; t < 25; t++) begin
      bias = int'($urandom_range(0, 1023)) - 512;
      for (int i = 0; i < 4; i++) begin
        xs[i] = int'($urandom_range(0, 31)) - 16;
        ws[i] = int'($urandom_range(0, 31)) - 16;
      end
      exp_s = model_sum(bias, xs, ws);
      run_eval(bias, xs, ws, 2, s, y, lat);
      n_checks++;
      if (s !== exp_s || y !== model_y(exp_s)) begin
        n_fail++;
        $display("FAIL random_%0d: bias=%0d sum=%0d y=%0d, required %0d %0d", t, bias, s, y,
                 exp_s, model_y(exp_s));
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_zero_neg();
    test_saturation();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
